// File: rtl/prog_load_sequencer.sv
// Boot loader: clears instr memory, streams prog_len words to base_addr+i, holds CPU in reset, then releases it.
// Latency: write strobe 1 cycle after each handshake; done/cpu_reset release RST_CYCLES+1 cycles after last handshake.
// Backpressure: in_ready high only in LOAD; in_valid low stalls LOAD indefinitely. Optional macro PROG_LOAD_CHECKSUM_EN.
module prog_load_sequencer #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 16,
  parameter int CLR_CYCLES = 1,
  parameter int RST_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       prog_len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              fm_rst,
  output logic              fm_write_enable,
  output logic [ADDR_W-1:0] fm_write_addr,
  output logic [DATA_W-1:0] fm_write_data,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic [15:0]       words_loaded,
  output logic [15:0]       checksum
);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_LOAD, S_HOLD, S_RUN} state_t;

  localparam logic [15:0] CLR_LAST = 16'(CLR_CYCLES - 1);
  localparam logic [15:0] RST_LAST = 16'(RST_CYCLES - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [15:0]         r_cnt;
  logic [ADDR_W-1:0]   r_base;
  logic [15:0]         r_len;
  logic [15:0]         r_words;
  logic                r_fm_rst;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic                r_cpu_reset;
  logic                r_busy;
  logic                r_done;
  logic                w_start_ok;
  logic                w_hs;
  logic                w_last;
  logic                w_fm_rst_nxt;
  logic                w_cpu_reset_nxt;
  logic                w_busy_nxt;
  logic                w_done_nxt;

  // start is only honoured between sessions; a handshake needs LOAD state
  assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_RUN));
  assign w_hs       = in_valid && (r_state == S_LOAD);
  assign w_last     = w_hs && ((r_words + 16'd1) == r_len);

  // State register; the phase counter restarts on every state change
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= (w_state_nxt != r_state) ? 16'd0 : r_cnt + 16'd1;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_state_nxt = S_CLEAR;
      S_CLEAR: if (r_cnt == CLR_LAST) w_state_nxt = (r_len == 16'd0) ? S_HOLD : S_LOAD;
      S_LOAD:  if (w_last) w_state_nxt = S_HOLD;
      S_HOLD:  if (r_cnt == RST_LAST) w_state_nxt = S_RUN;
      S_RUN:   if (w_start_ok) w_state_nxt = S_CLEAR;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so that every control output is a flop
  always_comb begin
    w_fm_rst_nxt    = (w_state_nxt == S_CLEAR);
    w_busy_nxt      = (w_state_nxt == S_CLEAR) || (w_state_nxt == S_LOAD) || (w_state_nxt == S_HOLD);
    w_cpu_reset_nxt = (w_state_nxt != S_RUN);
    w_done_nxt      = (w_state_nxt == S_RUN) && (r_state != S_RUN);
  end

  // Registered control outputs, write port and session bookkeeping
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fm_rst    <= 1'b0;
      r_cpu_reset <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_base      <= '0;
      r_len       <= '0;
      r_words     <= '0;
    end else begin
      r_fm_rst    <= w_fm_rst_nxt;
      r_cpu_reset <= w_cpu_reset_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_we        <= w_hs;
      // Address/data hold their last value between strobes
      if (w_hs) begin
        r_addr <= r_base + ADDR_W'(r_words);
        r_data <= in_data;
      end
      if (w_start_ok) begin
        r_base  <= base_addr;
        r_len   <= prog_len;
        r_words <= '0;
      end else if (w_hs) begin
        r_words <= r_words + 16'd1;
      end
    end
  end

`ifdef PROG_LOAD_CHECKSUM_EN
  logic [15:0] r_sum;

  // Running wrapping sum, updated alongside each write and cleared by start
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sum <= '0;
    end else if (w_start_ok) begin
      r_sum <= '0;
    end else if (w_hs) begin
      r_sum <= r_sum + 16'(in_data);
    end
  end

  assign checksum = r_sum;
`else
  assign checksum = 16'd0;
`endif

  assign in_ready        = (r_state == S_LOAD);
  assign fm_rst          = r_fm_rst;
  assign fm_write_enable = r_we;
  assign fm_write_addr   = r_addr;
  assign fm_write_data   = r_data;
  assign cpu_reset       = r_cpu_reset;
  assign busy            = r_busy;
  assign done            = r_done;
  assign words_loaded    = r_words;

endmodule

// File: tb/tb_prog_load_sequencer.sv
// Bench for prog_load_sequencer: randomized sessions against a queue-based reference of expected writes.
// Stimulus issues start/words; a negedge monitor pops expected writes and compares them.
// Session tasks check phase timing (clear, load, hold, run) cycle by cycle.
module tb_prog_load_sequencer;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 16;
  localparam int CLR_C  = 1;
  localparam int RST_C  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [15:0]       prog_len;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              fm_rst;
  logic              fm_write_enable;
  logic [ADDR_W-1:0] fm_write_addr;
  logic [DATA_W-1:0] fm_write_data;
  logic              cpu_reset;
  logic              busy;
  logic              done;
  logic [15:0]       words_loaded;
  logic [15:0]       checksum;

  typedef struct packed {
    logic [31:0] a;
    logic [15:0] d;
  } wr_t;

  wr_t         exp_q[$];
  logic [15:0] stim[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        prev_hs  = 1'b0;

  prog_load_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CLR_CYCLES(CLR_C), .RST_CYCLES(RST_C)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .prog_len(prog_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .fm_rst(fm_rst),
    .fm_write_enable(fm_write_enable), .fm_write_addr(fm_write_addr),
    .fm_write_data(fm_write_data), .cpu_reset(cpu_reset), .busy(busy), .done(done),
    .words_loaded(words_loaded), .checksum(checksum)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: a write strobe must follow exactly the cycle after each handshake,
  // and each write must match the next expected (address, data) pair.
  always @(negedge clk) begin
    wr_t e;
    chk("write_strobe_timing", {31'd0, fm_write_enable}, {31'd0, prev_hs});
    if (fm_write_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", fm_write_addr, e.a);
        chk("write_data", {16'd0, fm_write_data}, {16'd0, e.d});
      end
    end
    prev_hs = in_valid && in_ready && reset;
  end

  // Global watchdog so the run always terminates
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full session. Reference: word i goes to (b+i) mod 2^32, checksum is the
  // 16-bit wrapping sum. mode 0: back-to-back, 1: valid every other cycle with
  // ignored start pulses, 2: random valid.
  task automatic session(input logic [31:0] b, input int len, input int mode);
    logic [15:0] sum;
    logic [31:0] exp_sum;
    int          sent;
    int          cyc;
    logic        v;
    sum = 16'd0;
    for (int i = 0; i < len; i++) begin
      exp_q.push_back('{a: b + 32'(i), d: stim[i]});
      sum = sum + stim[i];
    end
`ifdef PROG_LOAD_CHECKSUM_EN
    exp_sum = {16'd0, sum};
`else
    exp_sum = 32'd0;
`endif
    start = 1'b1; base_addr = b; prog_len = 16'(len);
    tick();
    start = 1'b0; base_addr = $urandom; prog_len = 16'($urandom);
    for (int c = 0; c < CLR_C; c++) begin
      chk("clear_fm_rst", {31'd0, fm_rst}, 32'd1);
      chk("clear_busy", {31'd0, busy}, 32'd1);
      chk("clear_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      chk("clear_in_ready", {31'd0, in_ready}, 32'd0);
      chk("clear_words", {16'd0, words_loaded}, 32'd0);
      tick();
    end
    chk("after_clear_fm_rst", {31'd0, fm_rst}, 32'd0);
    sent = 0;
    cyc  = 0;
    while (sent < len) begin
      chk("load_in_ready", {31'd0, in_ready}, 32'd1);
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2) == 0;
        default: v = 1'($urandom_range(0, 1));
      endcase
      in_valid = v;
      in_data  = v ? stim[sent] : 16'($urandom);
      start    = (mode == 1) && !v;
      tick();
      if (v) sent++;
      cyc++;
      if (cyc > 2000) begin
        chk("load_cycle_budget", 32'(cyc), 32'd0);
        break;
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;
    for (int c = 0; c < RST_C; c++) begin
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      chk("hold_busy", {31'd0, busy}, 32'd1);
      chk("hold_done", {31'd0, done}, 32'd0);
      tick();
    end
    chk("run_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    chk("run_done", {31'd0, done}, 32'd1);
    chk("run_busy", {31'd0, busy}, 32'd0);
    chk("run_words_loaded", {16'd0, words_loaded}, 32'(len));
    chk("run_checksum", {16'd0, checksum}, exp_sum);
    chk("run_pending_writes", 32'(exp_q.size()), 32'd0);
    if (len > 0) chk("run_addr_hold", fm_write_addr, b + 32'(len - 1));
    tick();
    chk("run_done_pulse", {31'd0, done}, 32'd0);
    chk("run_cpu_reset_stays", {31'd0, cpu_reset}, 32'd0);
  endtask

  task automatic rand_words(input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(16'($urandom));
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; base_addr = '0; prog_len = '0;
    in_valid = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("rst_fm_rst", {31'd0, fm_rst}, 32'd0);
    chk("rst_we", {31'd0, fm_write_enable}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_addr", fm_write_addr, 32'd0);
    chk("rst_data", {16'd0, fm_write_data}, 32'd0);
    chk("rst_words", {16'd0, words_loaded}, 32'd0);
    chk("rst_checksum", {16'd0, checksum}, 32'd0);
    reset = 1'b1;
    tick();
    chk("idle_cpu_reset", {31'd0, cpu_reset}, 32'd1);

    // Directed program, back-to-back then with toggling valid (start from RUN)
    stim = '{16'hC95F, 16'h639F, 16'h1F3D, 16'h1F3D, 16'h03BF};
    session(32'h20, 5, 0);
    session(32'h20, 5, 1);

    // Empty program: clear straight into hold
    stim.delete();
    session(32'h1000, 0, 0);

    // Address wrap
    rand_words(3);
    session(32'hFFFF_FFFE, 3, 2);

    // Abort after two of five words
    rand_words(5);
    exp_q.push_back('{a: 32'h40, d: stim[0]});
    exp_q.push_back('{a: 32'h41, d: stim[1]});
    start = 1'b1; base_addr = 32'h40; prog_len = 16'd5;
    tick();
    start = 1'b0;
    repeat (CLR_C) tick();
    in_valid = 1'b1; in_data = stim[0];
    tick();
    in_data = stim[1];
    tick();
    in_data = stim[2];
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("abort_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
    chk("abort_words", {16'd0, words_loaded}, 32'd0);
    repeat (4) begin
      tick();
      chk("abort_idle_in_ready", {31'd0, in_ready}, 32'd0);
      chk("abort_idle_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    end
    in_valid = 1'b0;
    chk("abort_pending_writes", 32'(exp_q.size()), 32'd0);

    // Random sessions from IDLE and RUN
    for (int s = 0; s < 5; s++) begin
      int n;
      n = $urandom_range(0, 8);
      rand_words(n);
      session($urandom, n, $urandom_range(0, 2));
    end

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
